// File: rtl/pan_pkg.sv
//------------------------------------------------------------------------------
// pan_pkg : shared constants for the pan controller (FSM codes, geometry).
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package pan_pkg;

  localparam int c_STATE_W = 2;
  localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
  localparam logic [c_STATE_W-1:0] c_ST_PAN_R = 2'd1;
  localparam logic [c_STATE_W-1:0] c_ST_PAN_L = 2'd2;

  localparam int c_POS_W               = 9;
  localparam int c_STEP_PX             = 8;
  localparam int c_MAX_STEPS_DEF       = 240;
  localparam int c_DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//------------------------------------------------------------------------------
// btn_debounce : 2-flop synchronizer followed by a consecutive-count debouncer.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce
  import pan_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  input  logic btn,
  output logic db
);

  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample agreeing with the stable value restarts the run of disagreements.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= r_sync2;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign db = r_stable;

endmodule

`default_nettype wire

// File: rtl/pan_ctrl.sv
//------------------------------------------------------------------------------
// pan_ctrl : button-driven horizontal pan, one step per FRAME_DIV frames.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module pan_ctrl
  import pan_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
  parameter int FRAME_DIV       = 1,
  parameter int MAX_STEPS       = c_MAX_STEPS_DEF
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic               btn_r,
  input  logic               btn_l,
  input  logic               frame_tick,
  output logic               shift_r,
  output logic               shift_l,
  output logic [c_POS_W-1:0] pan_pos,
  output logic               at_limit_l,
  output logic               at_limit_r
);

  localparam int c_DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(FRAME_DIV - 1);
  localparam logic [c_POS_W-1:0] c_MAX_POS  = c_POS_W'(MAX_STEPS);

  logic                 w_db_r;
  logic                 w_db_l;
  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_state_next;
  logic [c_DIV_W-1:0]   r_div;
  logic                 w_step_r;
  logic                 w_step_l;
  logic [c_POS_W-1:0]   w_pos_next;
  logic [c_POS_W-1:0]   r_pan_pos;
  logic                 r_at_limit_l;
  logic                 r_at_limit_r;
  logic                 r_shift_r;
  logic                 r_shift_l;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .btn        (btn_r),
    .db         (w_db_r)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .btn        (btn_l),
    .db         (w_db_l)
  );

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) r_state <= c_ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Reversal always lands in IDLE first, so direction changes cost one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_db_r && !w_db_l && !r_at_limit_r)
          w_state_next = c_ST_PAN_R;
        else if (w_db_l && !w_db_r && !r_at_limit_l)
          w_state_next = c_ST_PAN_L;
      end
      c_ST_PAN_R: begin
        if (!w_db_r || w_db_l || r_at_limit_r)
          w_state_next = c_ST_IDLE;
      end
      c_ST_PAN_L: begin
        if (!w_db_l || w_db_r || r_at_limit_l)
          w_state_next = c_ST_IDLE;
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_step_r   = 1'b0;
    w_step_l   = 1'b0;
    w_pos_next = r_pan_pos;
    case (r_state)
      c_ST_PAN_R: w_step_r = frame_tick && (r_div == '0) && !r_at_limit_r;
      c_ST_PAN_L: w_step_l = frame_tick && (r_div == '0) && !r_at_limit_l;
      default: ;
    endcase
    if (w_step_r)
      w_pos_next = r_pan_pos + c_POS_W'(1);
    else if (w_step_l)
      w_pos_next = r_pan_pos - c_POS_W'(1);
  end

  // Every PAN entry comes from IDLE, so holding the divider at 0 there clears it on entry.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)
      r_div <= '0;
    else if (r_state == c_ST_IDLE)
      r_div <= '0;
    else if (frame_tick)
      r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_W'(1);
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_pan_pos    <= '0;
      r_at_limit_l <= 1'b1;
      r_at_limit_r <= 1'b0;
      r_shift_r    <= 1'b0;
      r_shift_l    <= 1'b0;
    end else begin
      r_pan_pos    <= w_pos_next;
      r_at_limit_l <= (w_pos_next == '0);
      r_at_limit_r <= (w_pos_next == c_MAX_POS);
      r_shift_r    <= w_step_r;
      r_shift_l    <= w_step_l;
    end
  end

  assign shift_r    = r_shift_r;
  assign shift_l    = r_shift_l;
  assign pan_pos    = r_pan_pos;
  assign at_limit_l = r_at_limit_l;
  assign at_limit_r = r_at_limit_r;

endmodule

`default_nettype wire

// File: tb/tb_pan_ctrl.sv
//------------------------------------------------------------------------------
// tb_pan_ctrl : directed self-checking bench for pan_ctrl (three parameter sets).
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pan_ctrl;
  import pan_pkg::*;

  logic clk_100MHz = 1'b0;
  logic reset_n    = 1'b0;
  logic btn_r      = 1'b0;
  logic btn_l      = 1'b0;
  logic frame_tick = 1'b0;

  // dut: defaults; dut_m: MAX_STEPS=3; dut_f: FRAME_DIV=4
  logic       shift_r0, shift_l0, atl0, atr0;
  logic [8:0] pos0;
  logic       shift_r_m, shift_l_m, atl_m, atr_m;
  logic [8:0] pos_m;
  logic       shift_r_f, shift_l_f, atl_f, atr_f;
  logic [8:0] pos_f;

  int checks   = 0;
  int failures = 0;

  int       pr0, pl0, stray0, pr_m, pl_m, pl_f, stray_f;
  bit       idle0, idle_m;
  bit [7:0] mask_f;

  always #5 clk_100MHz = ~clk_100MHz;

  pan_ctrl #(.DEBOUNCE_CYCLES(4), .FRAME_DIV(1), .MAX_STEPS(240)) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .btn_r(btn_r), .btn_l(btn_l),
    .frame_tick(frame_tick), .shift_r(shift_r0), .shift_l(shift_l0),
    .pan_pos(pos0), .at_limit_l(atl0), .at_limit_r(atr0));

  pan_ctrl #(.DEBOUNCE_CYCLES(4), .FRAME_DIV(1), .MAX_STEPS(3)) dut_m (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .btn_r(btn_r), .btn_l(btn_l),
    .frame_tick(frame_tick), .shift_r(shift_r_m), .shift_l(shift_l_m),
    .pan_pos(pos_m), .at_limit_l(atl_m), .at_limit_r(atr_m));

  pan_ctrl #(.DEBOUNCE_CYCLES(4), .FRAME_DIV(4), .MAX_STEPS(240)) dut_f (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .btn_r(btn_r), .btn_l(btn_l),
    .frame_tick(frame_tick), .shift_r(shift_r_f), .shift_l(shift_l_f),
    .pan_pos(pos_f), .at_limit_l(atl_f), .at_limit_r(atr_f));

  task automatic do_reset();
    @(negedge clk_100MHz);
    reset_n = 1'b0; btn_r = 1'b0; btn_l = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;
  endtask

  // Accumulates what the outputs did; slot=1 is the cycle right after a tick.
  task automatic observe(input bit slot, input int idx);
    if (slot) begin
      if (shift_r0)  pr0++;
      if (shift_r_m) pr_m++;
      if (shift_r_f) mask_f[idx] = 1'b1;
    end else begin
      if (shift_r0)  stray0++;
      if (shift_r_f) stray_f++;
      if (shift_r_m) stray0++;
    end
    if (shift_l0)  pl0++;
    if (shift_l_m) pl_m++;
    if (shift_l_f) pl_f++;
    if (dut.r_state   != c_ST_IDLE) idle0  = 1'b0;
    if (dut_m.r_state != c_ST_IDLE) idle_m = 1'b0;
  endtask

  task automatic send_ticks(input int n);
    pr0 = 0; pl0 = 0; stray0 = 0; pr_m = 0; pl_m = 0; pl_f = 0; stray_f = 0;
    idle0 = 1'b1; idle_m = 1'b1; mask_f = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_100MHz); observe(1'b0, i); frame_tick = 1'b1;
      @(negedge clk_100MHz); observe(1'b1, i); frame_tick = 1'b0;
      @(negedge clk_100MHz); observe(1'b0, i);
      @(negedge clk_100MHz); observe(1'b0, i);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_100MHz);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pos0, pos_m, pos_f} !== 27'd0) begin
      failures++; $display("FAIL reset_pos got %0d/%0d/%0d expected 0", pos0, pos_m, pos_f);
    end
    checks++;
    if ({atl0, atl_m, atl_f} !== 3'b111) begin
      failures++; $display("FAIL reset_at_limit_l got %b expected 111", {atl0, atl_m, atl_f});
    end
    checks++;
    if ({atr0, atr_m, atr_f} !== 3'b000) begin
      failures++; $display("FAIL reset_at_limit_r got %b expected 000", {atr0, atr_m, atr_f});
    end
    checks++;
    if ({shift_r0, shift_l0, shift_r_m, shift_l_m, shift_r_f, shift_l_f} !== 6'b0) begin
      failures++; $display("FAIL reset_shift got %b expected 000000",
        {shift_r0, shift_l0, shift_r_m, shift_l_m, shift_r_f, shift_l_f});
    end
    checks++;
    if (dut.r_state !== c_ST_IDLE) begin
      failures++; $display("FAIL reset_state got %0d expected %0d", dut.r_state, c_ST_IDLE);
    end
    do_reset();
  endtask

  task automatic test_glitch();
    bit rose = 1'b0;
    int pulses = 0;
    do_reset();
    btn_r = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    btn_r = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_100MHz);
      if (dut.w_db_r) rose = 1'b1;
      if (shift_r0) pulses++;
    end
    checks++;
    if (rose !== 1'b0) begin
      failures++; $display("FAIL glitch_db_r got rise=%0d expected 0", rose);
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL glitch_shift_r got %0d pulses expected 0", pulses);
    end
    checks++;
    if (pos0 !== 9'd0) begin
      failures++; $display("FAIL glitch_pos got %0d expected 0", pos0);
    end
  endtask

  task automatic test_pan_right();
    do_reset();
    btn_r = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    send_ticks(10);
    checks++;
    if (pr0 !== 10) begin
      failures++; $display("FAIL pan_r_pulses got %0d expected 10", pr0);
    end
    checks++;
    if (stray0 !== 0) begin
      failures++; $display("FAIL pan_r_timing got %0d off-slot pulses expected 0", stray0);
    end
    checks++;
    if (pos0 !== 9'd10) begin
      failures++; $display("FAIL pan_r_pos got %0d expected 10", pos0);
    end
    checks++;
    if (pl0 !== 0) begin
      failures++; $display("FAIL pan_r_shift_l got %0d pulses expected 0", pl0);
    end
    btn_r = 1'b0;
  endtask

  task automatic test_left_at_zero();
    do_reset();
    btn_l = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    send_ticks(5);
    checks++;
    if (idle0 !== 1'b1) begin
      failures++; $display("FAIL left0_state got left IDLE expected stay IDLE");
    end
    checks++;
    if (pl0 !== 0) begin
      failures++; $display("FAIL left0_shift_l got %0d pulses expected 0", pl0);
    end
    checks++;
    if (atl0 !== 1'b1) begin
      failures++; $display("FAIL left0_at_limit_l got %b expected 1", atl0);
    end
    checks++;
    if (pos0 !== 9'd0) begin
      failures++; $display("FAIL left0_pos got %0d expected 0", pos0);
    end
    btn_l = 1'b0;
  endtask

  task automatic test_right_limit();
    do_reset();
    btn_r = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    send_ticks(6);
    checks++;
    if (pr_m !== 3) begin
      failures++; $display("FAIL limit_pulses got %0d expected 3", pr_m);
    end
    checks++;
    if (pos_m !== 9'd3) begin
      failures++; $display("FAIL limit_pos got %0d expected 3", pos_m);
    end
    checks++;
    if (atr_m !== 1'b1) begin
      failures++; $display("FAIL limit_at_limit_r got %b expected 1", atr_m);
    end
    checks++;
    if (dut_m.r_state !== c_ST_IDLE) begin
      failures++; $display("FAIL limit_state got %0d expected %0d", dut_m.r_state, c_ST_IDLE);
    end
    btn_l = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    send_ticks(4);
    checks++;
    if ((pr_m + pl_m) !== 0) begin
      failures++; $display("FAIL both_held_pulses got r=%0d l=%0d expected 0", pr_m, pl_m);
    end
    checks++;
    if (pos_m !== 9'd3) begin
      failures++; $display("FAIL both_held_pos got %0d expected 3", pos_m);
    end
    btn_r = 1'b0; btn_l = 1'b0;
  endtask

  task automatic test_frame_div();
    do_reset();
    btn_r = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    send_ticks(8);
    checks++;
    if (mask_f !== 8'b0001_0001 || stray_f !== 0) begin
      failures++; $display("FAIL div_pulse_ticks got mask=%b stray=%0d expected 00010001 stray=0",
        mask_f, stray_f);
    end
    checks++;
    if (pos_f !== 9'd2) begin
      failures++; $display("FAIL div_pos got %0d expected 2", pos_f);
    end
    btn_r = 1'b0;
  endtask

  task automatic test_reset_mid_pan();
    do_reset();
    btn_r = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    frame_tick = 1'b1;
    @(negedge clk_100MHz);
    frame_tick = 1'b0;
    checks++;
    if (shift_r0 !== 1'b1 || pos0 !== 9'd1) begin
      failures++; $display("FAIL midrst_pulse got shift_r=%b pos=%0d expected 1/1", shift_r0, pos0);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (shift_r0 !== 1'b0 || pos0 !== 9'd0 || atl0 !== 1'b1) begin
      failures++; $display("FAIL midrst_clear got shift_r=%b pos=%0d atl=%b expected 0/0/1",
        shift_r0, pos0, atl0);
    end
    checks++;
    if (dut.r_state !== c_ST_IDLE) begin
      failures++; $display("FAIL midrst_state got %0d expected %0d", dut.r_state, c_ST_IDLE);
    end
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_100MHz);
      frame_tick = 1'b0;
      if (c == 3) begin
        checks++;
        if (shift_r0 !== 1'b0) begin
          failures++; $display("FAIL midrst_tick_idle got shift_r=%b expected 0", shift_r0);
        end
      end
      if (c == 5) begin
        checks++;
        if (dut.w_db_r !== 1'b0) begin
          failures++; $display("FAIL midrst_db_early got %b expected 0", dut.w_db_r);
        end
      end
      if (c == 6) begin
        checks++;
        if (dut.w_db_r !== 1'b1) begin
          failures++; $display("FAIL midrst_db_rise got %b expected 1", dut.w_db_r);
        end
      end
      if (c == 7) begin
        checks++;
        if (dut.r_state !== c_ST_PAN_R) begin
          failures++; $display("FAIL midrst_resume_state got %0d expected %0d", dut.r_state, c_ST_PAN_R);
        end
      end
      if (c == 2) frame_tick = 1'b1;
    end
    frame_tick = 1'b1;
    @(negedge clk_100MHz);
    frame_tick = 1'b0;
    checks++;
    if (shift_r0 !== 1'b1 || pos0 !== 9'd1) begin
      failures++; $display("FAIL midrst_resume_pulse got shift_r=%b pos=%0d expected 1/1", shift_r0, pos0);
    end
    @(negedge clk_100MHz);
    checks++;
    if (shift_r0 !== 1'b0 || shift_l0 !== 1'b0) begin
      failures++; $display("FAIL midrst_pulse_width got r=%b l=%b expected 0/0", shift_r0, shift_l0);
    end
    btn_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_pan_right();
    test_left_at_zero();
    test_right_limit();
    test_frame_div();
    test_reset_mid_pan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
